// File: rtl/exu_fpu_issue_q.sv
// exu_fpu_issue_q: in-order issue queue between decode and a pipelined FPU.
// Latency: an enqueued op can issue the cycle after enqueue; results appear one cycle after fpu_out_valid.
// Backpressure: enq_ready drops when queued + in-flight ops reach DEPTH; the head is held until fpu_in_ready.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   flush / fpu_flush           kill all queued and in-flight ops (forwarded to the FPU the same cycle)
//   enq_*                       decode-side enqueue (op, op_mod, rm, three operands)
//   fcsr_frm                    dynamic rounding mode, used when the op's rm field is 3'b111
//   fpu_in_* / fpu_op* / fpu_rnd_mode / fpu_operands / fpu_tag_o
//                               head-of-queue issue interface; operands are {c, b, a} with a in the LSBs
//   fpu_out_valid / fpu_result / fpu_status / fpu_tag_i
//                               FPU completion
//   res_valid / res_data / res_tag
//                               registered writeback of each completion
//   fflags_o / fflags_clr       accumulated exception flags (only when RV_FPU_FFLAGS_EN is defined)
//   busy / occupancy            queued + in-flight op count
//
// Build option: RV_FPU_FFLAGS_EN enables fflags accumulation; otherwise fflags_o is tied to zero.

module exu_fpu_issue_q #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int TAGW  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               enq_valid,
  output logic               enq_ready,
  input  logic [3:0]         enq_op,
  input  logic               enq_op_mod,
  input  logic [2:0]         enq_rm,
  input  logic [WIDTH-1:0]   enq_a,
  input  logic [WIDTH-1:0]   enq_b,
  input  logic [WIDTH-1:0]   enq_c,
  input  logic [2:0]         fcsr_frm,
  output logic               fpu_in_valid,
  input  logic               fpu_in_ready,
  output logic [3:0]         fpu_op,
  output logic               fpu_op_mod,
  output logic [2:0]         fpu_rnd_mode,
  output logic [3*WIDTH-1:0] fpu_operands,
  output logic [TAGW-1:0]    fpu_tag_o,
  output logic               fpu_flush,
  input  logic               fpu_out_valid,
  input  logic [WIDTH-1:0]   fpu_result,
  input  logic [4:0]         fpu_status,
  input  logic [TAGW-1:0]    fpu_tag_i,
  output logic               res_valid,
  output logic [WIDTH-1:0]   res_data,
  output logic [TAGW-1:0]    res_tag,
  output logic [4:0]         fflags_o,
  input  logic               fflags_clr,
  output logic               busy,
  output logic [TAGW:0]      occupancy
);

  localparam logic [TAGW-1:0] PTR_LAST = TAGW'(DEPTH - 1);
  localparam logic [TAGW-1:0] PTR_ONE  = TAGW'(1);
  localparam logic [TAGW:0]   CNT_ONE  = (TAGW+1)'(1);
  localparam logic [TAGW:0]   CNT_FULL = (TAGW+1)'(DEPTH);
  localparam logic [2:0]      RM_DYN   = 3'b111;

  typedef struct packed {
    logic [3:0]       op;
    logic             op_mod;
    logic [2:0]       rm;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          enq_ent;
  entry_t          head;
  logic [TAGW-1:0] wr_ptr;
  logic [TAGW-1:0] rd_ptr;
  logic [TAGW-1:0] tag_cnt;
  logic [TAGW:0]   q_cnt;     // entries waiting in the FIFO
  logic [TAGW:0]   out_cnt;   // issued to the FPU, not yet completed
  logic            enq_fire;
  logic            issue_fire;
  logic            cmpl_vld;

  // Wraps explicitly at DEPTH-1 so a TAGW override wider than log2(DEPTH) still indexes correctly.
  function automatic logic [TAGW-1:0] ptr_inc(input logic [TAGW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  assign occupancy = q_cnt + out_cnt;
  assign busy      = (occupancy != '0);

  // Full check uses the registered occupancy only: a pop or completion this cycle frees a slot next cycle.
  assign enq_ready    = ~rst & ~flush & (occupancy < CNT_FULL);
  assign fpu_in_valid = ~rst & ~flush & (q_cnt != '0);
  assign fpu_flush    = ~rst & flush;

  assign enq_fire   = enq_valid & enq_ready;
  assign issue_fire = fpu_in_valid & fpu_in_ready;
  // Completions with nothing outstanding are spurious; completions during flush belong to killed ops.
  assign cmpl_vld   = fpu_out_valid & (out_cnt != '0) & ~flush;

  assign enq_ent = {enq_op, enq_op_mod, enq_rm, enq_a, enq_b, enq_c};

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem[wr_ptr] <= enq_ent;
    end
  end

  // The head is read from registered storage, so it stays stable while the FPU stalls,
  // and an entry written this cycle is not visible until the next.
  assign head         = mem[rd_ptr];
  assign fpu_op       = head.op;
  assign fpu_op_mod   = head.op_mod;
  assign fpu_rnd_mode = (head.rm == RM_DYN) ? fcsr_frm : head.rm;
  assign fpu_operands = {head.c, head.b, head.a};
  assign fpu_tag_o    = tag_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_cnt   <= '0;
      out_cnt <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_cnt   <= '0;
      out_cnt <= '0;
    end else begin
      if (enq_fire) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (issue_fire) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      // Issue moves an op from queued to outstanding; total occupancy only changes on enq/complete.
      q_cnt   <= q_cnt + (enq_fire ? CNT_ONE : '0) - (issue_fire ? CNT_ONE : '0);
      out_cnt <= out_cnt + (issue_fire ? CNT_ONE : '0) - (cmpl_vld ? CNT_ONE : '0);
    end
  end

  // Tag counter survives flush so tags of killed ops are never reused right away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_cnt <= '0;
    end else if (issue_fire) begin
      tag_cnt <= ptr_inc(tag_cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
    end else begin
      res_valid <= cmpl_vld;
      if (cmpl_vld) begin
        res_data <= fpu_result;
        res_tag  <= fpu_tag_i;
      end
    end
  end

`ifdef RV_FPU_FFLAGS_EN
  logic [4:0] fflags_base;

  // Clear takes effect before the same-cycle completion is OR-ed in.
  assign fflags_base = fflags_clr ? 5'b0 : fflags_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fflags_o <= '0;
    end else begin
      fflags_o <= cmpl_vld ? (fflags_base | fpu_status) : fflags_base;
    end
  end
`else
  logic unused_fflags;

  assign fflags_o      = 5'b0;
  assign unused_fflags = fflags_clr ^ (^fpu_status);
`endif

endmodule

// File: tb/tb_exu_fpu_issue_q.sv
`timescale 1ns/1ps
module tb_exu_fpu_issue_q;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int TAGW  = 2;

  logic               clk = 1'b0;
  logic               rst, flush;
  logic               enq_valid, enq_ready;
  logic [3:0]         enq_op;
  logic               enq_op_mod;
  logic [2:0]         enq_rm;
  logic [WIDTH-1:0]   enq_a, enq_b, enq_c;
  logic [2:0]         fcsr_frm;
  logic               fpu_in_valid, fpu_in_ready;
  logic [3:0]         fpu_op;
  logic               fpu_op_mod;
  logic [2:0]         fpu_rnd_mode;
  logic [3*WIDTH-1:0] fpu_operands;
  logic [TAGW-1:0]    fpu_tag_o;
  logic               fpu_flush;
  logic               fpu_out_valid;
  logic [WIDTH-1:0]   fpu_result;
  logic [4:0]         fpu_status;
  logic [TAGW-1:0]    fpu_tag_i;
  logic               res_valid;
  logic [WIDTH-1:0]   res_data;
  logic [TAGW-1:0]    res_tag;
  logic [4:0]         fflags_o;
  logic               fflags_clr;
  logic               busy;
  logic [TAGW:0]      occupancy;

  always #5 clk = ~clk;

  exu_fpu_issue_q #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_op(enq_op), .enq_op_mod(enq_op_mod), .enq_rm(enq_rm),
    .enq_a(enq_a), .enq_b(enq_b), .enq_c(enq_c),
    .fcsr_frm(fcsr_frm),
    .fpu_in_valid(fpu_in_valid), .fpu_in_ready(fpu_in_ready),
    .fpu_op(fpu_op), .fpu_op_mod(fpu_op_mod), .fpu_rnd_mode(fpu_rnd_mode),
    .fpu_operands(fpu_operands), .fpu_tag_o(fpu_tag_o), .fpu_flush(fpu_flush),
    .fpu_out_valid(fpu_out_valid), .fpu_result(fpu_result),
    .fpu_status(fpu_status), .fpu_tag_i(fpu_tag_i),
    .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
    .fflags_o(fflags_o), .fflags_clr(fflags_clr),
    .busy(busy), .occupancy(occupancy)
  );

  // Expected fflags values for the accumulate / clear-with-completion sequence.
`ifdef RV_FPU_FFLAGS_EN
  localparam logic [4:0] FF_ACC = 5'b10001;
  localparam logic [4:0] FF_CLR = 5'b00100;
`else
  localparam logic [4:0] FF_ACC = 5'b00000;
  localparam logic [4:0] FF_CLR = 5'b00000;
`endif

  int tests = 0;
  int fails = 0;

  // ---------------- reference model: queue of ops + in-flight count ----------------
  typedef struct packed {
    logic [3:0]  op;
    logic        mod;
    logic [2:0]  rm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } ent_t;

  ent_t        mq[$];
  int          m_outs;
  int          m_tag;
  logic        m_rv;
  logic [31:0] m_rd;
  logic [1:0]  m_rt;
  logic [4:0]  m_ff;

  task automatic model_reset();
    mq.delete();
    m_outs = 0; m_tag = 0; m_rv = 1'b0; m_rd = '0; m_rt = '0; m_ff = '0;
  endtask

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    flush = 0; enq_valid = 0; enq_op = '0; enq_op_mod = 0; enq_rm = '0;
    enq_a = '0; enq_b = '0; enq_c = '0; fcsr_frm = '0; fpu_in_ready = 0;
    fpu_out_valid = 0; fpu_result = '0; fpu_status = '0; fpu_tag_i = '0; fflags_clr = 0;
  endtask

  task automatic rand_op();
    enq_op = 4'($urandom); enq_op_mod = 1'($urandom); enq_rm = 3'($urandom);
    enq_a = $urandom; enq_b = $urandom; enq_c = $urandom;
  endtask

  // Compare every output against the model, mid-cycle after inputs are applied.
  task automatic settle();
    int occ;
    logic [2:0] rnd;
    #1;
    occ = mq.size() + m_outs;
    chk("enq_ready", 96'(enq_ready), 96'(!flush && occ < DEPTH));
    chk("fpu_in_valid", 96'(fpu_in_valid), 96'(!flush && mq.size() > 0));
    chk("fpu_flush", 96'(fpu_flush), 96'(flush));
    chk("occupancy", 96'(occupancy), 96'(occ));
    chk("busy", 96'(busy), 96'(occ != 0));
    chk("fpu_tag_o", 96'(fpu_tag_o), 96'(m_tag));
    chk("res_valid", 96'(res_valid), 96'(m_rv));
    chk("res_data", 96'(res_data), 96'(m_rd));
    chk("res_tag", 96'(res_tag), 96'(m_rt));
    chk("fflags_o", 96'(fflags_o), 96'(m_ff));
    if (mq.size() > 0) begin
      rnd = (mq[0].rm == 3'b111) ? fcsr_frm : mq[0].rm;
      chk("fpu_op", 96'(fpu_op), 96'(mq[0].op));
      chk("fpu_op_mod", 96'(fpu_op_mod), 96'(mq[0].mod));
      chk("fpu_rnd_mode", 96'(fpu_rnd_mode), 96'(rnd));
      chk("fpu_operands", fpu_operands, {mq[0].c, mq[0].b, mq[0].a});
    end
  endtask

  // Advance one clock and apply the queue rules to the model with the inputs seen at the edge.
  task automatic tick();
    int occ;
    bit enq, iss, compl;
    ent_t e;
    @(posedge clk);
    occ   = mq.size() + m_outs;
    compl = 0;
    if (flush) begin
      mq.delete();
      m_outs = 0;
      m_rv   = 0;
    end else begin
      enq   = enq_valid && (occ < DEPTH);
      iss   = (mq.size() > 0) && fpu_in_ready;
      compl = fpu_out_valid && (m_outs > 0);
      m_rv  = compl;
      if (compl) begin
        m_rd = fpu_result; m_rt = fpu_tag_i; m_outs--;
      end
      if (iss) begin
        void'(mq.pop_front());
        m_outs++;
        m_tag = (m_tag + 1) % DEPTH;
      end
      if (enq) begin
        e.op = enq_op; e.mod = enq_op_mod; e.rm = enq_rm;
        e.a = enq_a; e.b = enq_b; e.c = enq_c;
        mq.push_back(e);
      end
    end
`ifdef RV_FPU_FFLAGS_EN
    if (fflags_clr) m_ff = '0;
    if (compl) m_ff = m_ff | fpu_status;
`endif
    #1;
  endtask

  // ---------------- rounding-mode vectors ----------------
  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rm;
    logic [2:0]  frm;
    logic [31:0] res;
    logic [2:0]  exp_rnd;
  } rvec_t;

  rvec_t tbl [5];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int acc;
    int tag_before;
    int tags[$];
    int wexp [6];

    tbl[0] = '{4'h1, 3'b111, 3'b010, 32'h3F800000, 3'b010};
    tbl[1] = '{4'h2, 3'b001, 3'b100, 32'h40000000, 3'b001};
    tbl[2] = '{4'h3, 3'b111, 3'b100, 32'hBF800000, 3'b100};
    tbl[3] = '{4'h4, 3'b000, 3'b111, 32'h00000001, 3'b000};
    tbl[4] = '{4'h5, 3'b101, 3'b011, 32'h7FC00000, 3'b101};
    wexp   = '{0, 1, 2, 3, 0, 1};

    // ---- reset: handshakes held low even with flush/enq asserted ----
    idle();
    rst = 1; flush = 1; enq_valid = 1; fpu_in_ready = 1;
    #2;
    chk("rst_enq_ready", 96'(enq_ready), 96'(0));
    chk("rst_fpu_in_valid", 96'(fpu_in_valid), 96'(0));
    chk("rst_fpu_flush", 96'(fpu_flush), 96'(0));
    chk("rst_occupancy", 96'(occupancy), 96'(0));
    @(posedge clk); #1;
    rst = 0; idle(); model_reset();
    settle();
    chk("post_rst_tag", 96'(fpu_tag_o), 96'(0));
    chk("post_rst_busy", 96'(busy), 96'(0));
    tick();

    // ---- rounding-mode table: enqueue, issue with frm, complete ----
    for (int i = 0; i < 5; i++) begin
      idle(); rand_op(); enq_valid = 1; enq_op = tbl[i].op; enq_rm = tbl[i].rm;
      settle();
      chk("no_bypass", 96'(fpu_in_valid), 96'(0));
      tick();
      idle(); fcsr_frm = tbl[i].frm; fpu_in_ready = 1;
      settle();
      chk("tbl_rnd_mode", 96'(fpu_rnd_mode), 96'(tbl[i].exp_rnd));
      chk("tbl_op", 96'(fpu_op), 96'(tbl[i].op));
      tick();
      idle(); fpu_out_valid = 1; fpu_result = tbl[i].res; fpu_tag_i = 2'(i);
      settle(); tick();
      idle(); settle();
      chk("tbl_res_data", 96'(res_data), 96'(tbl[i].res));
      tick();
    end

    // ---- fill to full with FPU stalled: 5 attempts, 4 accepted ----
    idle(); acc = 0;
    for (int i = 0; i < 5; i++) begin
      rand_op(); enq_valid = 1; enq_op = 4'(i + 1);
      settle();
      if (enq_ready) acc++;
      tick();
    end
    idle();
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("full_accepted", 96'(acc), 96'(4));
      chk("full_enq_ready", 96'(enq_ready), 96'(0));
      chk("full_occupancy", 96'(occupancy), 96'(4));
      chk("stall_head_op", 96'(fpu_op), 96'(1));
      tick();
    end
    idle(); fpu_in_ready = 1;
    for (int i = 0; i < 4; i++) begin settle(); tick(); end
    idle(); fpu_out_valid = 1;
    for (int i = 0; i < 4; i++) begin fpu_result = $urandom; settle(); tick(); end

    // ---- result pipelining ----
    idle(); rand_op(); enq_valid = 1; settle(); tick();
    idle(); fpu_in_ready = 1; settle(); tick();
    idle(); fpu_out_valid = 1; fpu_result = 32'h3F800000; fpu_tag_i = 2'd2;
    settle(); tick();
    idle(); settle();
    chk("pipe_res_valid", 96'(res_valid), 96'(1));
    chk("pipe_res_data", 96'(res_data), 96'(32'h3F800000));
    chk("pipe_res_tag", 96'(res_tag), 96'(2));
    tick();
    settle();
    chk("pipe_res_valid_drop", 96'(res_valid), 96'(0));
    tick();

    // ---- fflags accumulate, then clear with same-cycle completion ----
    idle(); fflags_clr = 1; settle(); tick();
    idle(); rand_op(); enq_valid = 1; settle(); tick();
    rand_op(); fpu_in_ready = 1; settle(); tick();
    rand_op(); settle(); tick();
    idle(); fpu_in_ready = 1; settle(); tick();
    idle(); fpu_out_valid = 1; fpu_status = 5'b00001; settle(); tick();
    fpu_status = 5'b10000; settle(); tick();
    idle(); settle();
    chk("fflags_accum", 96'(fflags_o), 96'(FF_ACC));
    tick();
    idle(); fpu_out_valid = 1; fpu_status = 5'b00100; fflags_clr = 1; settle(); tick();
    idle(); settle();
    chk("fflags_clr_cmpl", 96'(fflags_o), 96'(FF_CLR));
    tick();

    // ---- flush with 2 outstanding, 2 queued, and a same-cycle completion ----
    idle(); rand_op(); enq_valid = 1; settle(); tick();
    rand_op(); fpu_in_ready = 1; settle(); tick();
    rand_op(); settle(); tick();
    rand_op(); fpu_in_ready = 0; settle(); tick();
    idle(); settle();
    chk("pre_flush_occ", 96'(occupancy), 96'(4));
    tag_before = int'(fpu_tag_o);
    flush = 1; fpu_out_valid = 1; fpu_result = $urandom; fpu_in_ready = 1;
    settle();
    chk("flush_fpu_flush", 96'(fpu_flush), 96'(1));
    chk("flush_enq_ready", 96'(enq_ready), 96'(0));
    chk("flush_in_valid", 96'(fpu_in_valid), 96'(0));
    tick();
    idle(); settle();
    chk("flush_res_valid", 96'(res_valid), 96'(0));
    chk("flush_occupancy", 96'(occupancy), 96'(0));
    chk("flush_tag_kept", 96'(fpu_tag_o), 96'(tag_before));
    tick();

    // ---- asynchronous reset mid-operation ----
    idle(); rand_op(); enq_valid = 1; settle(); tick();
    rand_op(); fpu_in_ready = 1; settle(); tick();
    rst = 1; flush = 1; enq_valid = 1;
    #1;
    model_reset();
    chk("midrst_occupancy", 96'(occupancy), 96'(0));
    chk("midrst_enq_ready", 96'(enq_ready), 96'(0));
    chk("midrst_in_valid", 96'(fpu_in_valid), 96'(0));
    chk("midrst_fpu_flush", 96'(fpu_flush), 96'(0));
    chk("midrst_tag", 96'(fpu_tag_o), 96'(0));
    @(posedge clk); #1;
    rst = 0; idle();

    // ---- tag wrap: 6 back-to-back issues, completions every cycle ----
    for (int c = 0; c < 7; c++) begin
      idle(); rand_op(); enq_valid = (c < 6); fpu_in_ready = 1;
      fpu_out_valid = 1; fpu_result = $urandom; fpu_tag_i = 2'($urandom);
      settle();
      if (fpu_in_valid && fpu_in_ready) tags.push_back(int'(fpu_tag_o));
      tick();
    end
    chk("wrap_count", 96'(tags.size()), 96'(6));
    for (int i = 0; i < 6 && i < tags.size(); i++) chk("wrap_tag", 96'(tags[i]), 96'(wexp[i]));
    idle(); fpu_out_valid = 1;
    for (int i = 0; i < 2; i++) begin settle(); tick(); end

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 600; n++) begin
      idle(); rand_op();
      flush         = ($urandom_range(0, 19) == 0);
      enq_valid     = 1'($urandom);
      fcsr_frm      = 3'($urandom);
      fpu_in_ready  = ($urandom_range(0, 2) != 0);
      fpu_out_valid = ($urandom_range(0, 2) != 0);
      fpu_result    = $urandom;
      fpu_status    = 5'($urandom);
      fpu_tag_i     = 2'($urandom);
      fflags_clr    = ($urandom_range(0, 9) == 0);
      settle(); tick();
    end

    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
